// File: rtl/apb_subordinate_ni.sv
// APB completer end of the network interface.
// Each APB transfer from the local requester becomes one request packet on the
// TX FIFO; the matching response packet popped from the RX FIFO completes the
// transfer. Only one transfer is outstanding at a time, and a response timeout
// keeps a lost response from hanging the bus.

package ni_pkg;

    // APB request side, driven by the local requester
    typedef struct packed {
        logic [31:0] PADDR;
        logic        PSELx;
        logic        PENABLE;
        logic        PWRITE;
        logic [31:0] PWDATA;
    } apb_req_s;

    // APB completion side, driven back to the requester
    typedef struct packed {
        logic [31:0] PRDATA;
        logic        PREADY;
        logic        PSLVERR;
    } apb_resp_s;

    typedef struct packed {
        logic [14:0] data_bits;
    } flit_s;

    // Request: flit0 = {addr, write}; flits 1..3 carry the 32-bit write data
    typedef struct packed {
        flit_s [3:0] body_flit;
    } req_packet_s;

    // Response: flits 0..1 and flit2[14:13] carry read data, flit2[12] is the error
    typedef struct packed {
        flit_s [2:0] body_flit;
    } resp_packet_s;

    // Write data carried by a request packet
    function automatic logic [31:0] get_data(req_packet_s p);
        return {p.body_flit[1].data_bits,
                p.body_flit[2].data_bits,
                p.body_flit[3].data_bits[14:13]};
    endfunction

    // Build a request packet from the latched APB setup phase
    function automatic req_packet_s pack_req(logic pwrite, logic [13:0] paddr,
                                             logic [31:0] pwdata);
        req_packet_s p;
        p = '0;
        p.body_flit[0].data_bits        = {paddr, pwrite};
        p.body_flit[1].data_bits        = pwdata[31:17];
        p.body_flit[2].data_bits        = pwdata[16:2];
        p.body_flit[3].data_bits[14:13] = pwdata[1:0];
        return p;
    endfunction

    // Read data carried by a response packet
    function automatic logic [31:0] get_resp_data(resp_packet_s p);
        return {p.body_flit[0].data_bits,
                p.body_flit[1].data_bits,
                p.body_flit[2].data_bits[14:13]};
    endfunction

    // Error flag carried by a response packet
    function automatic logic get_resp_err(resp_packet_s p);
        return p.body_flit[2].data_bits[12];
    endfunction

endpackage

module apb_subordinate_ni
    import ni_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int DROP_W         = 3
) (
    input  logic         PCLK,
    input  logic         PRESETn,
    input  apb_req_s     in_apb_sigs,
    output apb_resp_s    op_apb_sigs,
    output req_packet_s  out_trans_pkt,
    input  logic         tx_fifo_full,
    output logic         tx_fifo_wreq,
    input  resp_packet_s in_trans_pkt,
    input  logic         rx_fifo_empty,
    output logic         rx_fifo_rreq
);

    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST =
        TO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [DROP_W-1:0] DROP_MAX = '1;

    typedef enum logic [2:0] {
        IDLE, PUSH, WAIT_RESP, POP, CAPT, DONE, DROP, DROP_W8
    } state_t;

    state_t state, state_nxt;

    // registered outputs and their next values
    logic [31:0]       prdata_q,  prdata_d;
    logic              pready_q,  pready_d;
    logic              pslverr_q, pslverr_d;
    logic              wreq_q,    wreq_d;
    logic              rreq_q,    rreq_d;
    req_packet_s       pkt_q,     pkt_d;

    // bookkeeping
    logic [TO_W-1:0]   to_cnt,    to_cnt_d;
    logic [DROP_W-1:0] drop_cnt,  drop_cnt_d;

    logic setup, access, timeout_hit;

    assign setup  = in_apb_sigs.PSELx & ~in_apb_sigs.PENABLE;
    assign access = in_apb_sigs.PSELx &  in_apb_sigs.PENABLE;

    // a zero TIMEOUT_CYCLES means wait for the response forever
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (to_cnt == TO_LAST);

    // Address bits above the packet field and the spare response bits are not carried
    logic unused_bits;
    assign unused_bits = ^{in_apb_sigs.PADDR[31:14],
                           in_trans_pkt.body_flit[2].data_bits[11:0]};

    // State register and all registered outputs
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state     <= IDLE;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            wreq_q    <= 1'b0;
            rreq_q    <= 1'b0;
            pkt_q     <= '0;
            to_cnt    <= '0;
            drop_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            prdata_q  <= prdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            wreq_q    <= wreq_d;
            rreq_q    <= rreq_d;
            pkt_q     <= pkt_d;
            to_cnt    <= to_cnt_d;
            drop_cnt  <= drop_cnt_d;
        end
    end

    // Next-state decode; a fresh setup phase wins over draining a stale response
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (setup)
                    state_nxt = PUSH;
                else if ((drop_cnt != '0) && !rx_fifo_empty)
                    state_nxt = DROP;
            end
            PUSH:      if (!tx_fifo_full) state_nxt = WAIT_RESP;
            WAIT_RESP: begin
                if (!rx_fifo_empty)
                    state_nxt = POP;
                else if (timeout_hit)
                    state_nxt = DONE;
            end
            POP:       state_nxt = CAPT;
            CAPT:      state_nxt = DONE;
            DONE:      state_nxt = IDLE;
            DROP:      state_nxt = DROP_W8;
            DROP_W8:   state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // Output and datapath next values; strobes default low, data holds
    always_comb begin
        prdata_d   = prdata_q;
        pready_d   = 1'b0;
        pslverr_d  = pslverr_q;
        wreq_d     = 1'b0;
        rreq_d     = 1'b0;
        pkt_d      = pkt_q;
        to_cnt_d   = to_cnt;
        drop_cnt_d = drop_cnt;
        case (state)
            IDLE: begin
                pslverr_d = 1'b0;
                if (setup)
                    pkt_d = pack_req(in_apb_sigs.PWRITE, in_apb_sigs.PADDR[13:0],
                                     in_apb_sigs.PWRITE ? in_apb_sigs.PWDATA : 32'h0);
            end
            PUSH: begin
                if (!tx_fifo_full) begin
                    wreq_d   = 1'b1;
                    to_cnt_d = '0;
                end
            end
            WAIT_RESP: begin
                to_cnt_d = to_cnt + 1'b1;
                if (rx_fifo_empty && timeout_hit) begin
                    // forced error completion; the late response gets drained later
                    pslverr_d = 1'b1;
                    prdata_d  = '0;
                    if (drop_cnt != DROP_MAX)
                        drop_cnt_d = drop_cnt + 1'b1;
                end
            end
            POP:  rreq_d = 1'b1;
            CAPT: begin
                prdata_d  = get_resp_data(in_trans_pkt);
                pslverr_d = get_resp_err(in_trans_pkt);
            end
            DONE: begin
                // a requester that walked away gets no PREADY
                pready_d = access;
                if (!access)
                    pslverr_d = 1'b0;
            end
            DROP: begin
                rreq_d     = 1'b1;
                drop_cnt_d = drop_cnt - 1'b1;
            end
            default: ;
        endcase
    end

    assign op_apb_sigs.PRDATA  = prdata_q;
    assign op_apb_sigs.PREADY  = pready_q;
    assign op_apb_sigs.PSLVERR = pslverr_q;
    assign out_trans_pkt       = pkt_q;
    assign tx_fifo_wreq        = wreq_q;
    assign rx_fifo_rreq        = rreq_q;

endmodule

// File: tb/tb_apb_subordinate_ni.sv
// Bench for apb_subordinate_ni: APB requester, TX/RX FIFO models and a response
// scoreboard; responses are matched to transfers in FIFO order.
module tb_apb_subordinate_ni;
    import ni_pkg::*;

    localparam int TO = 16;

    logic         PCLK = 1'b0;
    logic         PRESETn;
    apb_req_s     apb;
    apb_resp_s    rsp;
    req_packet_s  tx_pkt;
    logic         tx_full;
    logic         wreq;
    resp_packet_s rx_pkt;
    logic         rx_empty;
    logic         rreq;

    apb_subordinate_ni #(.TIMEOUT_CYCLES(TO), .DROP_W(3)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .in_apb_sigs(apb), .op_apb_sigs(rsp),
        .out_trans_pkt(tx_pkt), .tx_fifo_full(tx_full), .tx_fifo_wreq(wreq),
        .in_trans_pkt(rx_pkt), .rx_fifo_empty(rx_empty), .rx_fifo_rreq(rreq)
    );

    always #5 PCLK = ~PCLK;

    typedef struct { logic [31:0] d; logic e; } exp_t;

    int checks = 0, errors = 0;
    int cyc = 0;
    int wreq_cnt = 0, rreq_cnt = 0, pready_cnt = 0;
    int wreq_cyc = 0, drop_cyc = 0;
    resp_packet_s rxq[$];
    exp_t sbq[$];
    bit pop_pend = 0;
    bit resp_en = 0;
    int resp_dly = 0;
    int pend = -1;
    logic [31:0] nxt_d = '0;
    logic nxt_e = 1'b0;
    logic exp_wr = 1'b0;
    logic [13:0] exp_addr = '0;
    logic [31:0] exp_wdata = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Response packet layout: data = {f0, f1, f2[14:13]}, err = f2[12], rest is junk
    function automatic resp_packet_s mk_resp(logic [31:0] d, logic e);
        resp_packet_s p;
        logic [11:0] junk;
        junk = 12'($urandom);
        p.body_flit[0].data_bits = d[31:17];
        p.body_flit[1].data_bits = d[16:2];
        p.body_flit[2].data_bits = {d[1:0], e, junk};
        return p;
    endfunction

    initial forever begin
        @(posedge PCLK);
        cyc++;
    end

    // FIFO models and monitor; DUT inputs only change on the falling edge
    initial begin
        rx_empty = 1'b1;
        rx_pkt   = '0;
        forever begin
            @(negedge PCLK);
            if (pop_pend && rxq.size() > 0) rxq.delete(0);
            pop_pend = rreq;
            if (rreq) begin
                rreq_cnt++;
                chk("rreq_nonempty", 32'(rxq.size() > 0), 1);
            end
            if (rsp.PREADY) pready_cnt++;
            if (pend > 0) pend--;
            if (wreq) begin
                wreq_cnt++;
                wreq_cyc = cyc;
                chk("pkt_wr",   32'(tx_pkt.body_flit[0].data_bits[0]), 32'(exp_wr));
                chk("pkt_addr", 32'(tx_pkt.body_flit[0].data_bits[14:1]), 32'(exp_addr));
                chk("pkt_data", get_data(tx_pkt), exp_wr ? exp_wdata : 32'h0);
                if (resp_en) pend = resp_dly;
            end
            if (pend == 0) begin
                rxq.push_back(mk_resp(nxt_d, nxt_e));
                sbq.push_back('{nxt_d, nxt_e});
                pend = -1;
            end
            rx_empty = (rxq.size() == 0);
            rx_pkt   = rx_empty ? '0 : rxq[0];
        end
    end

    // One APB transfer; exp_lat < 0 skips the wreq-to-PREADY latency check
    task automatic xfer(input logic wr, input logic [13:0] addr, input logic [31:0] wd,
                        input int full_cyc, input bit exp_to, input int exp_lat);
        int w0, r0, p0, lat, n;
        logic [31:0] rd;
        exp_t e;
        w0 = wreq_cnt; r0 = rreq_cnt; p0 = pready_cnt;
        @(negedge PCLK);
        exp_wr = wr; exp_addr = addr; exp_wdata = wd;
        apb.PSELx = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = wr;
        apb.PADDR = {18'($urandom), addr}; apb.PWDATA = wd;
        tx_full = (full_cyc > 0);
        @(negedge PCLK);
        apb.PENABLE = 1'b1;
        for (n = 0; n < 200; n++) begin
            if (tx_full) begin
                chk("full_no_wreq", 32'(wreq_cnt - w0), 0);
                chk("full_no_ready", 32'(rsp.PREADY), 0);
                if (n >= full_cyc) begin
                    tx_full  = 1'b0;
                    drop_cyc = cyc;
                end
            end
            if (rsp.PREADY) break;
            @(negedge PCLK);
        end
        chk("ready_seen", 32'(rsp.PREADY), 1);
        lat = cyc - wreq_cyc;
        rd  = rsp.PRDATA;
        if (exp_to) begin
            chk("to_pslverr", 32'(rsp.PSLVERR), 1);
            chk("to_prdata", rsp.PRDATA, 0);
            chk("to_lat_window", 32'(lat >= TO && lat <= TO + 2), 1);
        end else if (sbq.size() == 0) begin
            chk("sb_nonempty", 0, 1);
        end else begin
            e = sbq.pop_front();
            chk("prdata", rsp.PRDATA, e.d);
            chk("pslverr", 32'(rsp.PSLVERR), 32'(e.e));
            if (exp_lat >= 0) chk("latency", 32'(lat), 32'(exp_lat));
        end
        if (full_cyc > 0) chk("wreq_after_full", 32'(wreq_cyc - drop_cyc), 1);
        @(negedge PCLK);
        chk("pready_one_cycle", 32'(rsp.PREADY), 0);
        chk("pslverr_cleared", 32'(rsp.PSLVERR), 0);
        chk("prdata_hold", rsp.PRDATA, rd);
        apb.PSELx = 1'b0; apb.PENABLE = 1'b0;
        chk("wreq_count", 32'(wreq_cnt - w0), 1);
        chk("rreq_count", 32'(rreq_cnt - r0), exp_to ? 0 : 1);
        chk("pready_count", 32'(pready_cnt - p0), 1);
    endtask

    initial begin
        int r0, p0, w0;
        logic [31:0] d2;
        logic e2;
        PRESETn = 1'b0;
        apb = '0;
        tx_full = 1'b0;
        repeat (3) @(negedge PCLK);
        chk("rst_pready", 32'(rsp.PREADY), 0);
        chk("rst_pslverr", 32'(rsp.PSLVERR), 0);
        chk("rst_prdata", rsp.PRDATA, 0);
        chk("rst_wreq", 32'(wreq), 0);
        chk("rst_rreq", 32'(rreq), 0);
        chk("rst_pkt", 32'(tx_pkt != '0), 0);
        PRESETn = 1'b1;

        // directed write, then directed read with an error response
        resp_en = 1; resp_dly = 0; nxt_d = $urandom; nxt_e = 0;
        xfer(1'b1, 14'h0123, 32'hDEADBEEF, 0, 0, 4);
        nxt_d = 32'hA5A5_0F0F; nxt_e = 1;
        xfer(1'b0, 14'h3FFF, $urandom, 0, 0, 4);

        // TX FIFO full for 10 cycles
        nxt_d = $urandom; nxt_e = 0;
        xfer(1'b1, 14'h0AA5, $urandom, 10, 0, 4);

        // timeout, then a late response drained in IDLE
        resp_en = 0;
        xfer(1'b0, 14'h1234, $urandom, 0, 1, -1);
        r0 = rreq_cnt; p0 = pready_cnt;
        rxq.push_back(mk_resp($urandom, 1'b0));
        repeat (8) @(negedge PCLK);
        chk("late_dropped", 32'(rxq.size()), 0);
        chk("late_rreq", 32'(rreq_cnt - r0), 1);
        chk("late_no_ready", 32'(pready_cnt - p0), 0);
        // with the drop count back at zero a stray response waits for the next transfer
        d2 = $urandom; e2 = 1'($urandom);
        rxq.push_back(mk_resp(d2, e2));
        sbq.push_back('{d2, e2});
        repeat (6) @(negedge PCLK);
        chk("stray_kept", 32'(rxq.size()), 1);
        xfer(1'b1, 14'h2222, $urandom, 0, 0, 4);

        // requester abandons the transfer before completion
        resp_en = 1; resp_dly = 0; nxt_d = $urandom; nxt_e = 1;
        r0 = rreq_cnt; p0 = pready_cnt; w0 = wreq_cnt;
        @(negedge PCLK);
        exp_wr = 1'b0; exp_addr = 14'h0042; exp_wdata = '0;
        apb.PSELx = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
        apb.PADDR = 32'h0000_0042; apb.PWDATA = $urandom;
        @(negedge PCLK);
        apb.PENABLE = 1'b1;
        repeat (2) @(negedge PCLK);
        apb.PSELx = 1'b0; apb.PENABLE = 1'b0;
        repeat (10) @(negedge PCLK);
        chk("abandon_no_ready", 32'(pready_cnt - p0), 0);
        chk("abandon_wreq", 32'(wreq_cnt - w0), 1);
        chk("abandon_rreq", 32'(rreq_cnt - r0), 1);
        chk("abandon_consumed", 32'(rxq.size()), 0);
        if (sbq.size() > 0) void'(sbq.pop_front());

        // asynchronous reset while waiting for a response
        resp_en = 0;
        @(negedge PCLK);
        exp_wr = 1'b1; exp_addr = 14'h1555; exp_wdata = 32'hCAFE_F00D;
        apb.PSELx = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b1;
        apb.PADDR = 32'h0000_1555; apb.PWDATA = 32'hCAFE_F00D;
        @(negedge PCLK);
        apb.PENABLE = 1'b1;
        repeat (4) @(negedge PCLK);
        #2 PRESETn = 1'b0;
        #1;
        chk("arst_pready", 32'(rsp.PREADY), 0);
        chk("arst_pslverr", 32'(rsp.PSLVERR), 0);
        chk("arst_prdata", rsp.PRDATA, 0);
        chk("arst_wreq", 32'(wreq), 0);
        chk("arst_rreq", 32'(rreq), 0);
        chk("arst_pkt", 32'(tx_pkt != '0), 0);
        @(negedge PCLK);
        apb.PSELx = 1'b0; apb.PENABLE = 1'b0;
        PRESETn = 1'b1;
        resp_en = 1; resp_dly = 0; nxt_d = $urandom; nxt_e = 0;
        xfer(1'b1, 14'h0777, $urandom, 0, 0, 4);

        // back-to-back with the RX FIFO preloaded
        resp_en = 0;
        for (int i = 0; i < 3; i++) begin
            d2 = $urandom; e2 = 1'($urandom);
            rxq.push_back(mk_resp(d2, e2));
            sbq.push_back('{d2, e2});
        end
        for (int i = 0; i < 3; i++)
            xfer(1'($urandom), 14'($urandom), $urandom, 0, 0, 4);

        // randomized transfers
        resp_en = 1;
        for (int i = 0; i < 20; i++) begin
            int fc, dl;
            fc = $urandom_range(0, 2);
            dl = $urandom_range(0, 5);
            resp_dly = dl; nxt_d = $urandom; nxt_e = 1'($urandom);
            xfer(1'($urandom), 14'($urandom), $urandom, fc, 0, 4 + dl);
        end

        repeat (3) @(negedge PCLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
